// File: rtl/inbuf_vc_port_if.sv
// inbuf_vc_port_if: upstream link (si/di/ri) and internal switch side (deq/valid_int/q) of the input port
interface inbuf_vc_port_if #(
    parameter int WIDTH = 64
);
    logic             si;
    logic [WIDTH-1:0] di;
    logic             ri;
    logic             deq;
    logic             valid_int;
    logic [WIDTH-1:0] q;
    modport master (output si, di, deq, input ri, valid_int, q);
    modport slave  (input si, di, deq, output ri, valid_int, q);
endinterface

// File: rtl/inbuf_vc_port.sv
// inbuf_vc_port: receive-side port with even/odd single-flit VC buffers, written on polarity and read on ~polarity
// Ports: clk; reset (sync, active-high); polarity (global phase); link (si/di/ri upstream,
// deq/valid_int/q to the switch); full (per-VC occupancy, [0]=even); err (sticky protocol error);
// flit_cnt (accepted flits, wrapping)
module inbuf_vc_port #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    inbuf_vc_port_if.slave    link,
    output logic [1:0]        full,
    output logic              err,
    output logic [CNT_W-1:0]  flit_cnt
);
    typedef enum logic {EMPTY, FULL} vc_state_t;
    logic [WIDTH-1:0] buf_q [2];
    logic accept, dequeue;
    assign link.ri        = ~full[polarity];
    assign link.valid_int = full[~polarity];
    assign link.q         = buf_q[~polarity];
    assign accept  = link.si & link.ri & (link.di[WIDTH-1] == polarity);
    assign dequeue = link.deq & full[~polarity];
    // accept and dequeue never target the same VC, so each VC sees at most one of them
    for (genvar v = 0; v < 2; v++) begin : g_vc
        vc_state_t state, state_nxt;
        always_ff @(posedge clk) state <= reset ? EMPTY : state_nxt;
        always_comb begin
            state_nxt = state;
            state_nxt = (state == EMPTY && accept && polarity == 1'(v)) ? FULL :
                        (state == FULL && dequeue && polarity != 1'(v)) ? EMPTY : state;
        end
        assign full[v] = state == FULL;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            err      <= 1'b0;
            flit_cnt <= '0;
        end else begin
            if (accept) begin
                buf_q[polarity] <= link.di;
                flit_cnt        <= flit_cnt + CNT_W'(1);
            end
            // any strobe that is not accepted is either an overrun or a VC tag mismatch
            if (link.si && !accept) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_inbuf_vc_port.sv
// tb_inbuf_vc_port: directed and random stimulus, queue scoreboard against a behavioural model
module tb_inbuf_vc_port;
    logic        clk = 0;
    logic        reset = 0;
    logic        polarity = 0;
    logic [1:0]  full;
    logic        err;
    logic [15:0] flit_cnt;
    inbuf_vc_port_if #(.WIDTH(64)) link();
    inbuf_vc_port #(.WIDTH(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .polarity(polarity), .link(link),
        .full(full), .err(err), .flit_cnt(flit_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        bit          pre_ok;
        logic        pre_ri, pre_valid;
        logic [63:0] pre_q;
        logic [1:0]  full;
        logic        err;
        logic [15:0] cnt;
        logic        ri, valid;
        logic [63:0] q;
    } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;
    logic [1:0]  m_full;
    logic [63:0] m_buf [2];
    logic        m_err;
    logic [15:0] m_cnt;
    bit          known = 0;
    logic        pol = 1;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask
    task automatic step(input bit r, input bit s, input bit d, input logic [63:0] data);
        exp_t e;
        bit acc, drop;
        @(negedge clk);
        pol = ~pol;
        reset = r; polarity = pol; link.si = s; link.di = data; link.deq = d;
        e.pre_ok = known;
        e.pre_ri = !m_full[pol];
        e.pre_valid = m_full[!pol];
        e.pre_q = m_buf[!pol];
        if (r) begin
            m_full = 2'b00; m_buf[0] = '0; m_buf[1] = '0; m_err = 0; m_cnt = 0; known = 1;
        end else begin
            acc  = s && !m_full[pol] && data[63] == pol;
            drop = d && m_full[!pol];
            if (s && !acc) m_err = 1;
            if (acc) begin
                m_buf[pol] = data; m_full[pol] = 1; m_cnt = m_cnt + 16'd1;
            end
            if (drop) m_full[!pol] = 0;
        end
        e.full = m_full; e.err = m_err; e.cnt = m_cnt;
        e.ri = !m_full[pol]; e.valid = m_full[!pol]; e.q = m_buf[!pol];
        sb.push_back(e);
    endtask
    initial begin
        exp_t e;
        logic p_ri, p_v;
        logic [63:0] p_q;
        forever begin
            @(negedge clk);
            #2;
            p_ri = link.ri; p_v = link.valid_int; p_q = link.q;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.pre_ok) begin
                    chk("pre_ri", p_ri, e.pre_ri);
                    chk("pre_valid", p_v, e.pre_valid);
                    if (e.pre_valid) chk("pre_q", p_q, e.pre_q);
                end
                chk("full", full, e.full);
                chk("err", err, e.err);
                chk("flit_cnt", flit_cnt, e.cnt);
                chk("ri", link.ri, e.ri);
                chk("valid_int", link.valid_int, e.valid);
                if (e.valid) chk("q", link.q, e.q);
            end
        end
    end
    initial begin
        logic [63:0] data;
        bit r, s, d;
        logic np;
        link.si = 0; link.di = '0; link.deq = 0;
        step(1, 0, 0, 64'h0);
        step(1, 0, 0, 64'h0);
        step(0, 1, 0, 64'h0123_4567_89AB_CDEF);
        step(0, 0, 1, 64'h0);
        step(0, 1, 0, 64'h0000_0000_1111_0000);
        step(0, 0, 0, 64'h0);
        step(0, 1, 0, 64'h0000_0000_DEAD_BEEF);
        step(1, 0, 0, 64'h0);
        step(0, 0, 0, 64'h0);
        step(0, 1, 0, 64'h0000_0000_0000_0055);
        step(0, 1, 0, 64'h0000_0000_0000_AAAA);
        step(0, 1, 1, 64'h8000_0000_0000_BBBB);
        step(0, 1, 0, 64'h0000_0000_0000_AAAA);
        step(1, 1, 1, 64'h8000_0000_0000_CCCC);
        for (int i = 0; i < 500; i++) begin
            np = ~pol;
            r = $urandom_range(63) == 0;
            s = $urandom_range(99) < 70;
            d = $urandom_range(99) < 60;
            data = {$urandom, $urandom};
            data[63] = ($urandom_range(99) < 85) ? np : ~np;
            step(r, s, d, data);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
